// File: rtl/bram_fifo_ctrl_if.sv
// Bundle of the FIFO handshake and FAST_BRAM port pins driven by bram_fifo_ctrl.
// slave  : the controller itself (accepts ENQ/DEQ, drives the BRAM pins).
// master : the surrounding logic (producer, consumer and BRAM read data).
interface bram_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_WIDTH = 9
);
   logic                  ENQ;
   logic [DATA_WIDTH-1:0] ENQ_DATA;
   logic                  NOT_FULL;
   logic                  DEQ;
   logic [DATA_WIDTH-1:0] FIRST;
   logic                  NOT_EMPTY;
   logic [ADDR_WIDTH+1:0] COUNT;
   logic                  WEA;
   logic [ADDR_WIDTH-1:0] WR_ADDRA;
   logic [DATA_WIDTH-1:0] DIA;
   logic                  REB;
   logic [ADDR_WIDTH-1:0] RD_ADDRB;
   logic [DATA_WIDTH-1:0] DOB;

   modport slave (
      input  ENQ, ENQ_DATA, DEQ, DOB,
      output NOT_FULL, FIRST, NOT_EMPTY, COUNT, WEA, WR_ADDRA, DIA, REB, RD_ADDRB
   );

   modport master (
      output ENQ, ENQ_DATA, DEQ, DOB,
      input  NOT_FULL, FIRST, NOT_EMPTY, COUNT, WEA, WR_ADDRA, DIA, REB, RD_ADDRB
   );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller in front of a FAST_BRAM: port A write-only, port B read-only.
// Registered BRAM read data lands in a 2-entry skid buffer whose head is FIRST,
// giving a full-throughput FIFO of capacity DEPTH+2.
// Optional feature macro: BRAM_FIFO_BYPASS_EN -- when nothing older sits in the
// BRAM or in flight, an enqueue goes straight into the skid buffer (latency 1).
module bram_fifo_ctrl #(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_WIDTH = 9,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input logic             CLK,
   input logic             RST,
   bram_fifo_ctrl_if.slave bus
);
   localparam logic [ADDR_WIDTH:0]   MEM_FULL_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   MEM_ZERO_C = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH-1:0] PTR_ZERO_C = {ADDR_WIDTH{1'b0}};

   logic [ADDR_WIDTH-1:0] wptr_r;
   logic [ADDR_WIDTH-1:0] rptr_r;
   logic [ADDR_WIDTH:0]   mem_count_r;
   logic                  pending_r;
   logic [DATA_WIDTH-1:0] skid0_r;
   logic [DATA_WIDTH-1:0] skid1_r;
   logic [1:0]            skid_count_r;

   logic                  not_full_s;
   logic                  not_empty_s;
   logic                  do_enq_s;
   logic                  do_deq_s;
   logic                  issue_s;
   logic                  bypass_s;
   logic                  mem_wr_s;
   logic                  push_s;
   logic [DATA_WIDTH-1:0] push_data_s;
   logic [1:0]            after_pop_s;
   logic [2:0]            occ_s;
   logic [DATA_WIDTH-1:0] skid0_s;
   logic [DATA_WIDTH-1:0] skid1_s;
   logic [1:0]            skid_count_s;

   // Handshake decode and read-issue decision; DEQ frees a skid slot in the same cycle.
   always_comb begin
      not_full_s  = (mem_count_r != MEM_FULL_C);
      not_empty_s = (skid_count_r != 2'd0);
      do_enq_s    = bus.ENQ & not_full_s;
      do_deq_s    = bus.DEQ & not_empty_s;
      after_pop_s = skid_count_r - {1'b0, do_deq_s};
      // Slots already spoken for: skid contents plus a read still returning.
      occ_s       = {1'b0, skid_count_r} + {2'b00, pending_r} - {2'b00, do_deq_s};
      issue_s     = (mem_count_r != MEM_ZERO_C) & (occ_s < 3'd2);
`ifdef BRAM_FIFO_BYPASS_EN
      bypass_s    = do_enq_s & (mem_count_r == MEM_ZERO_C) & ~pending_r & (after_pop_s < 2'd2);
`else
      bypass_s    = 1'b0;
`endif
      mem_wr_s    = do_enq_s & ~bypass_s;
      // Bypass needs pending clear, so a capture and a bypass never collide.
      push_s      = pending_r | bypass_s;
      if (pending_r) begin
         push_data_s = bus.DOB;
      end else begin
         push_data_s = bus.ENQ_DATA;
      end
   end

   // Skid buffer next state: pop shifts the tail to the head, push fills the first free slot.
   always_comb begin
      skid0_s = skid0_r;
      skid1_s = skid1_r;
      if (do_deq_s) begin
         skid0_s = skid1_r;
      end else begin
         skid0_s = skid0_r;
      end
      if (push_s) begin
         if (after_pop_s == 2'd0) begin
            skid0_s = push_data_s;
         end else begin
            skid1_s = push_data_s;
         end
      end else begin
         skid1_s = skid1_r;
      end
      skid_count_s = after_pop_s + {1'b0, push_s};
   end

   // Pointer, occupancy and skid state; reset drops any in-flight read.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_r       <= PTR_ZERO_C;
         rptr_r       <= PTR_ZERO_C;
         mem_count_r  <= MEM_ZERO_C;
         pending_r    <= 1'b0;
         skid0_r      <= {DATA_WIDTH{1'b0}};
         skid1_r      <= {DATA_WIDTH{1'b0}};
         skid_count_r <= 2'd0;
      end else begin
         wptr_r       <= wptr_r + {{(ADDR_WIDTH-1){1'b0}}, mem_wr_s};
         rptr_r       <= rptr_r + {{(ADDR_WIDTH-1){1'b0}}, issue_s};
         mem_count_r  <= mem_count_r + {{ADDR_WIDTH{1'b0}}, mem_wr_s}
                                     - {{ADDR_WIDTH{1'b0}}, issue_s};
         pending_r    <= issue_s;
         skid0_r      <= skid0_s;
         skid1_r      <= skid1_s;
         skid_count_r <= skid_count_s;
      end
   end

   assign bus.NOT_FULL  = not_full_s;
   assign bus.NOT_EMPTY = not_empty_s;
   assign bus.FIRST     = skid0_r;
   assign bus.COUNT     = {1'b0, mem_count_r}
                        + {{(ADDR_WIDTH+1){1'b0}}, pending_r}
                        + {{ADDR_WIDTH{1'b0}}, skid_count_r};
   assign bus.WEA       = mem_wr_s;
   assign bus.WR_ADDRA  = wptr_r;
   assign bus.DIA       = bus.ENQ_DATA;
   assign bus.REB       = issue_s;
   assign bus.RD_ADDRB  = rptr_r;
endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
FIFO controller that sits directly upstream of a FAST_BRAM instance and drives its address, enable and write-data pins. Port A of the BRAM is used write-only and port B read-only. The controller reads the BRAM's one-cycle registered read data back into a 2-entry output skid buffer. The result is a full-throughput enq/deq FIFO with first-word visibility, used for deep buffering between LEAP pipeline stages.

Parameters:
DATA_WIDTH, 36, entry width; must match the BRAM instance.
ADDR_WIDTH, 9, BRAM address width.
DEPTH, 1 << ADDR_WIDTH, BRAM entries; must be a power of two so pointers wrap naturally.

Ports:
CLK  in  1  single clock for all logic.
RST  in  1  synchronous reset, active-high.
ENQ  in  1  enqueue request.
ENQ_DATA  in  DATA_WIDTH  enqueue payload.
NOT_FULL  out  1  enqueue will be accepted this cycle.
DEQ  in  1  dequeue request.
FIRST  out  DATA_WIDTH  head entry.
NOT_EMPTY  out  1  FIRST is valid.
COUNT  out  ADDR_WIDTH+2  total occupancy: BRAM + in-flight read + skid.
WEA  out  1  BRAM port A write enable.
WR_ADDRA  out  ADDR_WIDTH  BRAM port A write address (wptr).
DIA  out  DATA_WIDTH  BRAM port A write data; equals ENQ_DATA.
REB  out  1  BRAM port B read strobe (issue).
RD_ADDRB  out  ADDR_WIDTH  BRAM port B read address (rptr).
DOB  in  DATA_WIDTH  BRAM port B read data, valid the cycle after REB.
BRAM REA, WEB, RD_ADDRA, WR_ADDRB are tied to 0 at the instantiation site.

Behaviour:
- State: wptr and rptr (ADDR_WIDTH bits, wrap modulo DEPTH); mem_count (ADDR_WIDTH+1 bits, 0..DEPTH); pending flag (read issued last cycle); skid buffer of 2 entries with skid_count 0..2.
- Reset: all of the above cleared and FIRST register = 0. Outputs: NOT_FULL=1, NOT_EMPTY=0, FIRST=0, COUNT=0, WEA=0, REB=0.
- NOT_FULL = (mem_count != DEPTH), taken from registers only. Total capacity is DEPTH+2.
- Enqueue: do_enq = ENQ & NOT_FULL. WEA = do_enq; WR_ADDRA = wptr. On do_enq, wptr increments. ENQ while full is ignored: no write, no state change.
- Dequeue: do_deq = DEQ & NOT_EMPTY. NOT_EMPTY = (skid_count != 0). FIRST = skid head entry. On do_deq, skid pops. DEQ while empty is ignored.
- Read issue: issue = (mem_count != 0) & (skid_count + pending - do_deq < 2). REB = issue; RD_ADDRB = rptr. On issue, rptr increments and pending is set next cycle.
- DEQ feeds issue combinationally; this is a permitted path.
- Capture: when pending is set, DOB is pushed into the skid tail this cycle. Capture and pop may happen in the same cycle.
- mem_count next = mem_count + do_enq - issue.
- COUNT = mem_count + pending + skid_count.
- Collision-free by construction: a read only targets entries written in earlier cycles. wptr == rptr with issue=1 would need mem_count == DEPTH, and WEA=0 then.
- Enqueue-to-visible latency into an empty FIFO: 3 cycles. Write in cycle t, read issued in t+1, DOB captured at the end of t+2, NOT_EMPTY=1 in t+3.
- Steady state with simultaneous ENQ and DEQ every cycle: one entry per cycle, no bubbles.
- Reset mid-operation: an outstanding read is dropped, and DOB is not captured in the cycle after RST. All entries are lost.

Optional Feature:
BRAM_FIFO_BYPASS_EN
- Defined: when mem_count==0, pending==0 and skid_count - do_deq < 2, an accepted ENQ writes ENQ_DATA directly into the skid tail. WEA=0 for that enqueue and wptr is unchanged. NOT_EMPTY rises the next cycle (latency 1). Ordering is preserved because bypass only occurs when nothing is older in BRAM or in flight.
- Undefined: every enqueue goes through the BRAM (latency 3).

Test Plan:
- Reset, ENQ 0xA5 in cycle 0 -> COUNT=1 from cycle 1; REB=1 with RD_ADDRB=0 in cycle 1; NOT_EMPTY=1 and FIRST=0xA5 in cycle 3 (cycle 1 with BRAM_FIFO_BYPASS_EN).
- ADDR_WIDTH=2, ENQ 7 words 1..7 back-to-back with no DEQ -> first 6 accepted; NOT_FULL=0 on the 7th with WEA=0; COUNT=6; FIRST=1; then 6 DEQs return 1..6.
- Stream 1000 incrementing words with ENQ and DEQ held high (DEQ gated on NOT_EMPTY) -> after the 3-cycle prime, NOT_EMPTY stays 1 and one word is dequeued per cycle in order.
- ADDR_WIDTH=2, random ENQ/DEQ for 200 words -> output order matches input through multiple pointer wraps; COUNT always equals scoreboard depth.
- DEQ while empty, and ENQ while NOT_FULL=0 -> no state change, WEA=0, REB=0, COUNT unchanged.
- Assert RST one cycle after REB=1 with 0x3C in flight -> cycle after reset: NOT_EMPTY=0, COUNT=0, 0x3C never appears on FIRST; next ENQ 0x11 is written at WR_ADDRA=0.
